// File: rtl/fir_result_byte_tx_if.sv
// -----------------------------------------------------------------------------
// fir_result_byte_tx_if
// Bundles the signals between the FIR result port, the byte transmitter and
// the pin-side byte sink.
//   y_dat/y_vld   : FIR result word and its one-cycle strobe
//   byte_*        : valid/ready byte stream toward the pins
//   clr_ovr       : clears the sticky overrun flag
//   busy/overrun  : transmitter status
// Modports:
//   master : the environment (FIR core + pin sink) driving the transmitter
//   slave  : the transmitter itself
// -----------------------------------------------------------------------------
interface fir_result_byte_tx_if #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
);
    logic [WORD_W-1:0] y_dat;
    logic              y_vld;
    logic              byte_rdy;
    logic              clr_ovr;
    logic [BYTE_W-1:0] byte_dat;
    logic              byte_vld;
    logic              byte_last;
    logic              busy;
    logic              overrun;

    modport master (
        output y_dat, y_vld, byte_rdy, clr_ovr,
        input  byte_dat, byte_vld, byte_last, busy, overrun
    );

    modport slave (
        input  y_dat, y_vld, byte_rdy, clr_ovr,
        output byte_dat, byte_vld, byte_last, busy, overrun
    );
endinterface

// File: rtl/fir_result_byte_tx.sv
// -----------------------------------------------------------------------------
// fir_result_byte_tx
// Takes each WORD_W-bit FIR result and streams it out as BYTE_W-bit beats over
// a valid/ready handshake. A one-word hold buffer absorbs a result that
// arrives while a word is still being sent; a result arriving when the hold
// buffer is already occupied is dropped and flagged on the sticky overrun.
//
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   bus     : fir_result_byte_tx_if.slave
//             in : y_dat, y_vld, byte_rdy, clr_ovr
//             out: byte_dat, byte_vld, byte_last, busy, overrun
//
// Parameters:
//   WORD_W    : result word width (multiple of BYTE_W)
//   BYTE_W    : beat width
//   LSB_FIRST : 1 = least significant byte first, 0 = most significant first
//
// Build option:
//   FIR_TX_CHECKSUM_EN : append one XOR-of-data-bytes checksum beat per word;
//                        byte_last then marks the checksum beat.
// -----------------------------------------------------------------------------
module fir_result_byte_tx #(
    parameter int WORD_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_result_byte_tx_if.slave  bus
);
    localparam int NBYTES = WORD_W / BYTE_W;
`ifdef FIR_TX_CHECKSUM_EN
    localparam int NBEATS = NBYTES + 1;
`else
    localparam int NBEATS = NBYTES;
`endif
    // Sized for NBYTES+1 so the checksum beat index still fits.
    localparam int CNT_W = $clog2(NBYTES + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] word_q, word_nxt;
    logic [WORD_W-1:0] hold_q, hold_nxt;
    logic              hold_full, hold_full_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ovr, ovr_nxt;

    logic              sending;
    logic              xfer;
    logic              last_beat;
    logic              end_word;
    logic              drain;
    logic              drop;
    logic [BYTE_W-1:0] beat;

    // Byte 'idx' of the word in transmit order.
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                    input logic [CNT_W-1:0]  idx);
        logic [BYTE_W-1:0] b;
        b = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == CNT_W'(k)) begin
                if (LSB_FIRST != 0)
                    b = w[k*BYTE_W +: BYTE_W];
                else
                    b = w[(NBYTES-1-k)*BYTE_W +: BYTE_W];
            end
        end
        return b;
    endfunction

`ifdef FIR_TX_CHECKSUM_EN
    function automatic logic [BYTE_W-1:0] xor_bytes(input logic [WORD_W-1:0] w);
        logic [BYTE_W-1:0] x;
        x = '0;
        for (int k = 0; k < NBYTES; k++)
            x = x ^ w[k*BYTE_W +: BYTE_W];
        return x;
    endfunction

    assign beat = (cnt == CNT_W'(NBYTES)) ? xor_bytes(word_q) : pick_byte(word_q, cnt);
`else
    assign beat = pick_byte(word_q, cnt);
`endif

    assign sending   = (state == SEND);
    assign xfer      = sending && bus.byte_rdy;
    assign last_beat = (cnt == CNT_W'(NBEATS - 1));
    assign end_word  = xfer && last_beat;
    // Hold is emptied into the word register this cycle, so it can take a new word.
    assign drain     = end_word && hold_full;

    assign bus.byte_vld  = sending;
    assign bus.byte_dat  = sending ? beat : '0;
    assign bus.byte_last = sending && last_beat;
    assign bus.busy      = sending || hold_full;
    assign bus.overrun   = ovr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_q    <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            ovr       <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_q    <= word_nxt;
            hold_q    <= hold_nxt;
            hold_full <= hold_full_nxt;
            cnt       <= cnt_nxt;
            ovr       <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        word_nxt      = word_q;
        hold_nxt      = hold_q;
        hold_full_nxt = hold_full;
        cnt_nxt       = cnt;
        drop          = 1'b0;

        case (state)
            IDLE: begin
                if (bus.y_vld) begin
                    word_nxt  = bus.y_dat;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (end_word) begin
                    cnt_nxt = '0;
                    if (hold_full) begin
                        word_nxt      = hold_q;
                        hold_full_nxt = 1'b0;
                    end else if (bus.y_vld) begin
                        word_nxt = bus.y_dat;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (xfer) begin
                    cnt_nxt = cnt + 1'b1;
                end

                // A new result that was not loaded straight into the word
                // register goes to hold if there is room, else it is lost.
                if (bus.y_vld && !(end_word && !hold_full)) begin
                    if (!hold_full || drain) begin
                        hold_nxt      = bus.y_dat;
                        hold_full_nxt = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)
            ovr_nxt = 1'b1;
        else if (bus.clr_ovr)
            ovr_nxt = 1'b0;
        else
            ovr_nxt = ovr;
    end
endmodule

// File: tb/tb_fir_result_byte_tx.sv
module tb_fir_result_byte_tx;
    localparam int WORD_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int LSB_FIRST = 1;
    localparam int NBYTES    = WORD_W / BYTE_W;
`ifdef FIR_TX_CHECKSUM_EN
    localparam int NBEATS = NBYTES + 1;
`else
    localparam int NBEATS = NBYTES;
`endif

    logic clk;
    logic rst_n;

    fir_result_byte_tx_if #(.WORD_W(WORD_W), .BYTE_W(BYTE_W)) bus ();

    fir_result_byte_tx #(
        .WORD_W(WORD_W), .BYTE_W(BYTE_W), .LSB_FIRST(LSB_FIRST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_xfer = 0;

    // Scoreboard entries: {byte_last, byte_dat}
    logic [BYTE_W:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats for one accepted word, in transmit order.
    task automatic push_word(input logic [WORD_W-1:0] w);
        logic [BYTE_W-1:0] b;
        logic [BYTE_W-1:0] x;
        x = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (LSB_FIRST != 0) b = w[k*BYTE_W +: BYTE_W];
            else                b = w[(NBYTES-1-k)*BYTE_W +: BYTE_W];
            x = x ^ b;
            sb.push_back({(k == NBEATS-1), b});
        end
`ifdef FIR_TX_CHECKSUM_EN
        sb.push_back({1'b1, x});
`endif
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((sb.size() != 0 || bus.busy) && i < budget) begin
            tick();
            i++;
        end
        chk("drain_done", 32'(sb.size() == 0 && !bus.busy), 32'd1);
    endtask

    // Monitor: compares every transferred beat against the scoreboard and
    // checks that a stalled beat stays put until it is taken.
    logic              stall_pend = 1'b0;
    logic [BYTE_W-1:0] held_dat;
    logic              held_last;
    logic [BYTE_W:0]   exp_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("stall_vld", 32'(bus.byte_vld), 32'd1);
                chk("stall_dat", 32'(bus.byte_dat), 32'(held_dat));
                chk("stall_last", 32'(bus.byte_last), 32'(held_last));
            end
            if (bus.byte_vld && bus.byte_rdy) begin
                n_xfer++;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    chk("byte_dat", 32'(bus.byte_dat), 32'(exp_e[BYTE_W-1:0]));
                    chk("byte_last", 32'(bus.byte_last), 32'(exp_e[BYTE_W]));
                end
            end
            stall_pend = bus.byte_vld && !bus.byte_rdy;
            held_dat   = bus.byte_dat;
            held_last  = bus.byte_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int gaps;
        logic [3:0] pat;

        rst_n        = 1'b0;
        bus.y_dat    = '0;
        bus.y_vld    = 1'b0;
        bus.byte_rdy = 1'b0;
        bus.clr_ovr  = 1'b0;
        #12;
        chk("rst_vld", 32'(bus.byte_vld), 32'd0);
        chk("rst_last", 32'(bus.byte_last), 32'd0);
        chk("rst_dat", 32'(bus.byte_dat), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single word, sink always ready
        bus.byte_rdy = 1'b1;
        bus.y_dat    = 32'hDEADBEEF;
        bus.y_vld    = 1'b1;
        push_word(32'hDEADBEEF);
        tick();
        bus.y_vld = 1'b0;
        chk("t1_lat_vld", 32'(bus.byte_vld), 32'd1);
        chk("t1_first", 32'(bus.byte_dat), (LSB_FIRST != 0) ? 32'hEF : 32'hDE);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        wait_drain(20);
        chk("t1_idle_vld", 32'(bus.byte_vld), 32'd0);
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);

        // Same word with the sink stalling 1,0,0,1,...
        pat = 4'b1001;
        bus.y_dat = 32'hDEADBEEF;
        bus.y_vld = 1'b1;
        push_word(32'hDEADBEEF);
        tick();
        bus.y_vld = 1'b0;
        x0 = n_xfer;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            bus.byte_rdy = pat[i % 4];
            tick();
        end
        chk("t2_count", 32'(n_xfer - x0), 32'(NBEATS));
        bus.byte_rdy = 1'b1;
        wait_drain(10);
        chk("t2_idle_vld", 32'(bus.byte_vld), 32'd0);

        // Back-to-back words through the hold buffer, no bubble allowed
        bus.y_dat = 32'h11223344;
        bus.y_vld = 1'b1;
        push_word(32'h11223344);
        tick();
        gaps = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) begin
                bus.y_dat = 32'h55667788;
                bus.y_vld = 1'b1;
                push_word(32'h55667788);
            end else begin
                bus.y_vld = 1'b0;
            end
            if (sb.size() != 0 && !bus.byte_vld) gaps++;
            tick();
        end
        chk("t3_gaps", 32'(gaps), 32'd0);
        wait_drain(10);

        // Overrun: in flight + held + dropped with sink stalled
        bus.byte_rdy = 1'b0;
        bus.y_dat = 32'hA1A2A3A4; bus.y_vld = 1'b1; push_word(32'hA1A2A3A4);
        tick();
        bus.y_dat = 32'hB1B2B3B4; push_word(32'hB1B2B3B4);
        tick();
        chk("t4_no_ovr_yet", 32'(bus.overrun), 32'd0);
        bus.y_dat = 32'hC1C2C3C4;
        tick();
        bus.y_vld = 1'b0;
        chk("t4_ovr_set", 32'(bus.overrun), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd1);
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        chk("t4_ovr_clr", 32'(bus.overrun), 32'd0);
        // Drop and clear together: the drop wins
        bus.y_dat = 32'hD1D2D3D4; bus.y_vld = 1'b1; bus.clr_ovr = 1'b1;
        tick();
        bus.y_vld = 1'b0; bus.clr_ovr = 1'b0;
        chk("t4_set_wins", 32'(bus.overrun), 32'd1);
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        bus.byte_rdy = 1'b1;
        wait_drain(30);
        chk("t4_ovr_after", 32'(bus.overrun), 32'd0);

        // Asynchronous reset mid-word
        bus.y_dat = 32'hCAFEF00D;
        bus.y_vld = 1'b1;
        if (LSB_FIRST != 0) begin
            sb.push_back({1'b0, 8'h0D});
            sb.push_back({1'b0, 8'hF0});
        end else begin
            sb.push_back({1'b0, 8'hCA});
            sb.push_back({1'b0, 8'hFE});
        end
        tick();
        bus.y_vld = 1'b0;
        tick();
        tick();
        chk("t5_two_sent", 32'(sb.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(bus.byte_vld), 32'd0);
        chk("t5_rst_dat", 32'(bus.byte_dat), 32'd0);
        chk("t5_rst_last", 32'(bus.byte_last), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_stay_idle", 32'(bus.byte_vld), 32'd0);
        bus.y_dat = 32'hA5A5A5A5;
        bus.y_vld = 1'b1;
        push_word(32'hA5A5A5A5);
        tick();
        bus.y_vld = 1'b0;
        x0 = n_xfer;
        wait_drain(20);
        chk("t5_count", 32'(n_xfer - x0), 32'(NBEATS));

        // Word whose checksum (when enabled) is 0x04
        bus.y_dat = 32'h01020304;
        bus.y_vld = 1'b1;
        push_word(32'h01020304);
        tick();
        bus.y_vld = 1'b0;
        x0 = n_xfer;
        wait_drain(20);
        chk("t6_count", 32'(n_xfer - x0), 32'(NBEATS));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fir_result_byte_tx.md
Name: fir_result_byte_tx

Overview:
- Transmit end of the FIR core's 32-bit result port, packaged for the 8-bit TinyTapeout pin budget.
- Captures each new FIR output word (32-bit data plus one-cycle valid) and sends it out as a sequence of bytes.
- Uses a valid/ready byte handshake toward the pins (uo_out data, uio strobes).
- Has a one-word holding buffer, so a result arriving during transmission is not lost.

Parameters:
- WORD_W, 32, width of the FIR result word; must be a multiple of BYTE_W.
- BYTE_W, 8, width of one output beat.
- LSB_FIRST, 1, 1 = byte 0 is bits [7:0]; 0 = byte 0 is the most significant byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- y_dat  in  WORD_W  FIR result word.
- y_vld  in  1  one-cycle pulse: y_dat is a new result.
- byte_rdy  in  1  downstream can accept a byte this cycle.
- clr_ovr  in  1  synchronous clear of the overrun flag.
- byte_dat  out  BYTE_W  current output byte.
- byte_vld  out  1  byte_dat is valid.
- byte_last  out  1  current byte is the final byte of the word.
- busy  out  1  a word is being sent or is held.
- overrun  out  1  sticky: a result was dropped.

Behaviour:
- Reset: asynchronous on rst_n low; all state clears immediately.
  - byte_vld=0, byte_last=0, byte_dat=0, busy=0, overrun=0.
  - State = IDLE, holding buffer empty, byte counter = 0.
  - A word in flight is discarded; no partial word resumes after reset.
- Transfer rule: a byte transfers on a rising edge where byte_vld=1 and byte_rdy=1.
  - While byte_vld=1 and byte_rdy=0, byte_dat and byte_last hold stable.
  - byte_vld never deasserts without a transfer (except on reset).
- NBYTES = WORD_W/BYTE_W (4 at defaults). Byte counter is ceil(log2(NBYTES+1)) bits wide.
- State machine:
  - IDLE: byte_vld=0. When y_vld=1, load y_dat into the shift register, clear the counter, go to SEND. First byte is valid the cycle after y_vld (latency 1).
  - SEND: byte_vld=1. byte_dat = byte[counter], ordered per LSB_FIRST. byte_last=1 when counter=NBYTES-1. Each transfer increments the counter.
  - On transfer of the last byte:
    - If the hold buffer is full, load the shift register from hold, empty hold, counter=0, stay in SEND. No idle bubble between words.
    - Else if y_vld=1 in the same cycle, load y_dat directly and stay in SEND.
    - Else go to IDLE.
- Holding buffer (one word): a y_vld arriving while in SEND is written to hold if hold is empty, or if hold is being drained into the shift register in the same cycle.
- Overrun: y_vld arrives while in SEND, hold is full, and hold is not draining that cycle.
  - The new word is dropped; the shift register and hold are unchanged.
  - overrun is set the next cycle and stays set until clr_ovr=1 or reset.
  - If clr_ovr and a new drop coincide, set wins.
- busy = (state==SEND) OR hold full.
- Counter wrap: the counter resets to 0 on every word load. It never runs past NBYTES-1.

Optional Feature:
- Macro: FIR_TX_CHECKSUM_EN.
- When defined:
  - An extra byte follows the NBYTES data bytes. Its value is the XOR of all data bytes of that word.
  - byte_last asserts on the checksum byte, not on data byte NBYTES-1.
  - Hold/reload and overrun rules apply at the checksum transfer instead of the last data byte.
- When undefined: exactly NBYTES bytes per word; no checksum logic is synthesized.

Test Plan:
1. Reset, then y_dat=0xDEADBEEF pulsed with byte_rdy=1 throughout -> byte_vld rises next cycle; bytes EF,BE,AD,DE on consecutive cycles; byte_last only on DE; then byte_vld=0, busy=0.
2. Same word with byte_rdy toggling 1,0,0,1,... -> byte_dat holds stable during every stall; exactly 4 transfers, in order; no duplicated or skipped bytes.
3. 0x11223344 then 0x55667788 pulsed 2 cycles apart, byte_rdy=1 -> second word is held; bytes 44,33,22,11,88,77,66,55 with no gap; byte_last on 11 and 55.
4. Three words pulsed on consecutive cycles with byte_rdy=0 -> first word in flight, second held, third dropped; overrun=1 on the cycle after the third pulse; clr_ovr pulse returns it to 0.
5. rst_n driven low after 2 of 4 bytes transferred -> outputs clear asynchronously; after release, a new 0xA5A5A5A5 sends all 4 bytes from byte 0.
6. With FIR_TX_CHECKSUM_EN defined, send 0x01020304 -> bytes 04,03,02,01 then 04, with byte_last on the 5th byte. With LSB_FIRST=0, the data order becomes 01,02,03,04.
